id_ex_stage: RTL and testbench

- Pipeline register between instruction decode and the ALU.
- Captures decoded operands and control on each clock, then resolves data hazards.
- Forwards results from EX/MEM and MEM/WB, and inserts a bubble on a load-use hazard.
- Presents ALUCtl, A and B directly to the ALU, plus the control bits needed by later stages.

---
 rtl/id_ex_stage.sv | 216 +++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register. It captures the decoded operands and control
//   bits of one instruction per clock and presents ALUCtl, A and B to the
//   ALU. It also resolves data hazards:
//     - forwards EX/MEM and MEM/WB results onto the stored rs / rt operands
//     - raises load_use and loads a bubble when the instruction in ID needs
//       the destination of a load that is currently in EX
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   hold                freeze every stored field (downstream stall)
//   flush               load a bubble (taken branch / jump)
//   id_*                decoded instruction from the ID stage
//   exmem_*, memwb_*    forwarding sources (write enable, index, value)
//   ex_*                stored instruction with forwarding applied
//   load_use            hazard flag back to IF/ID (freeze PC and IF/ID)
//
// Stall protocol: this stage has no valid/ready pair. id_valid marks a real
// instruction in ID. While load_use is high the upstream stages must hold
// their contents, and this stage absorbs the cycle by loading a bubble.
// While hold is high nothing here changes; load_use is still reported so
// IF/ID keeps stalling, but no bubble is inserted.
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [1:0]    id_alu_ctl,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alu_src,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic          ex_valid,
  output logic [1:0]    ex_alu_ctl,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          load_use
);

  // Stage occupancy. The state is visible on ex_valid.
  typedef enum logic {
    S_BUBBLE = 1'b0,
    S_INSTR  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    alu_ctl_q, alu_ctl_d;
  logic [DW-1:0] rs_data_q, rs_data_d;
  logic [DW-1:0] rt_data_q, rt_data_d;
  logic [DW-1:0] imm_q, imm_d;
  logic          alu_src_q, alu_src_d;
  logic [RW-1:0] rs_q, rs_d;
  logic [RW-1:0] rt_q, rt_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          mem_to_reg_q, mem_to_reg_d;

  logic [DW-1:0] rs_fwd, rt_fwd;

  // EX/MEM is the younger result, so it wins over MEM/WB. Register 0 is
  // hard-wired and never forwarded.
  function automatic logic [DW-1:0] forward(
    input logic [RW-1:0] idx,
    input logic [DW-1:0] raw,
    input logic          em_we,
    input logic [RW-1:0] em_rd,
    input logic [DW-1:0] em_val,
    input logic          mw_we,
    input logic [RW-1:0] mw_rd,
    input logic [DW-1:0] mw_val
  );
    logic [DW-1:0] r;
    r = raw;
    if (em_we && (em_rd != '0) && (em_rd == idx)) begin
      r = em_val;
    end else if (mw_we && (mw_rd != '0) && (mw_rd == idx)) begin
      r = mw_val;
    end
    return r;
  endfunction

  // A load in EX produces its data too late to forward to the next
  // instruction; a dependent instruction in ID must wait one cycle.
  always_comb begin
    load_use = (state_q == S_INSTR) && mem_read_q && id_valid &&
               (rd_q != '0) && ((rd_q == id_rs) || (rd_q == id_rt));
  end

  // Next-state / next-field logic. Default is to keep everything (hold).
  always_comb begin
    state_d      = state_q;
    alu_ctl_d    = alu_ctl_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    alu_src_d    = alu_src_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;

    if (flush || (!hold && (load_use || !id_valid))) begin
      // Bubble: control cleared so the slot has no side effects; data
      // fields are zeroed for determinism.
      state_d      = S_BUBBLE;
      alu_ctl_d    = '0;
      rs_data_d    = '0;
      rt_data_d    = '0;
      imm_d        = '0;
      alu_src_d    = 1'b0;
      rs_d         = '0;
      rt_d         = '0;
      rd_d         = '0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (!hold) begin
      state_d      = S_INSTR;
      alu_ctl_d    = id_alu_ctl;
      rs_data_d    = id_rs_data;
      rt_data_d    = id_rt_data;
      imm_d        = id_imm;
      alu_src_d    = id_alu_src;
      rs_d         = id_rs;
      rt_d         = id_rt;
      rd_d         = id_rd;
      reg_write_d  = id_reg_write;
      mem_read_d   = id_mem_read;
      mem_write_d  = id_mem_write;
      mem_to_reg_d = id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BUBBLE;
      alu_ctl_q    <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      alu_src_q    <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_ctl_q    <= alu_ctl_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      alu_src_q    <= alu_src_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  always_comb begin
    rs_fwd = forward(rs_q, rs_data_q, exmem_reg_write, exmem_rd, exmem_result,
                     memwb_reg_write, memwb_rd, memwb_result);
    rt_fwd = forward(rt_q, rt_data_q, exmem_reg_write, exmem_rd, exmem_result,
                     memwb_reg_write, memwb_rd, memwb_result);
  end

  // Shift amounts are taken from ex_b by the ALU; no masking here.
  assign ex_valid      = (state_q == S_INSTR);
  assign ex_alu_ctl    = alu_ctl_q;
  assign ex_a          = rs_fwd;
  assign ex_b          = alu_src_q ? imm_q : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed scenarios followed by randomized traffic for id_ex_stage. A
//   reference model holds "the instruction currently in EX" as a record and
//   derives every expected output from it and the current inputs.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk;
  logic          rst_n;
  logic          hold, flush, id_valid;
  logic [1:0]    id_alu_ctl;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic          id_alu_src;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic          exmem_reg_write;
  logic [RW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_reg_write;
  logic [RW-1:0] memwb_rd;
  logic [DW-1:0] memwb_result;
  logic          ex_valid;
  logic [1:0]    ex_alu_ctl;
  logic [DW-1:0] ex_a, ex_b, ex_store_data;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic          load_use;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_alu_ctl(id_alu_ctl),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_alu_ctl(ex_alu_ctl), .ex_a(ex_a), .ex_b(ex_b),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .load_use(load_use)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          valid;
    logic [1:0]    ctl;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic          src;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          mw;
    logic          m2r;
  } instr_t;

  instr_t m;  // instruction the model believes is sitting in EX

  function automatic logic model_hazard(instr_t cur);
    return cur.valid && cur.mr && id_valid && (cur.rd != 0) &&
           (cur.rd == id_rs || cur.rd == id_rt);
  endfunction

  function automatic logic [DW-1:0] model_value(logic [RW-1:0] idx, logic [DW-1:0] raw);
    if (idx == 0) return raw;
    if (exmem_reg_write && exmem_rd == idx) return exmem_result;
    if (memwb_reg_write && memwb_rd == idx) return memwb_result;
    return raw;
  endfunction

  function automatic instr_t model_next(instr_t cur);
    instr_t n;
    n = '0;
    if (flush) return n;
    if (hold) return cur;
    if (model_hazard(cur) || !id_valid) return n;
    n.valid = 1'b1;       n.ctl = id_alu_ctl;
    n.rs_data = id_rs_data; n.rt_data = id_rt_data; n.imm = id_imm;
    n.src = id_alu_src;   n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
    n.rw = id_reg_write;  n.mr = id_mem_read;
    n.mw = id_mem_write;  n.m2r = id_mem_to_reg;
    return n;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [DW-1:0] a_exp, rt_exp;
    a_exp  = model_value(m.rs, m.rs_data);
    rt_exp = model_value(m.rt, m.rt_data);
    check("ex_valid",      64'(ex_valid),      64'(m.valid));
    check("ex_alu_ctl",    64'(ex_alu_ctl),    64'(m.ctl));
    check("ex_a",          64'(ex_a),          64'(a_exp));
    check("ex_b",          64'(ex_b),          64'(m.src ? m.imm : rt_exp));
    check("ex_store_data", 64'(ex_store_data), 64'(rt_exp));
    check("ex_rd",         64'(ex_rd),         64'(m.rd));
    check("ex_reg_write",  64'(ex_reg_write),  64'(m.rw));
    check("ex_mem_read",   64'(ex_mem_read),   64'(m.mr));
    check("ex_mem_write",  64'(ex_mem_write),  64'(m.mw));
    check("ex_mem_to_reg", 64'(ex_mem_to_reg), 64'(m.m2r));
    check("load_use",      64'(load_use),      64'(model_hazard(m)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    instr_t nxt;
    nxt = model_next(m);
    @(posedge clk);
    #1;
    m = nxt;
    check_all();
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic clear_inputs();
    hold = 0; flush = 0; id_valid = 0; id_alu_ctl = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alu_src = 0;
    id_rs = 0; id_rt = 0; id_rd = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic drive_instr(input logic [1:0] ctl, input logic [DW-1:0] rsd,
                             input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
                             input logic src, input logic [RW-1:0] rs,
                             input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                             input logic rw, input logic mr);
    id_valid = 1; id_alu_ctl = ctl; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_alu_src = src; id_rs = rs; id_rt = rt; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = 0; id_mem_to_reg = mr;
  endtask

  task automatic randomize_id();
    id_valid      = ($urandom_range(0, 7) != 0);
    id_alu_ctl    = 2'($urandom_range(0, 3));
    id_rs_data    = $urandom;
    id_rt_data    = $urandom;
    id_imm        = $urandom;
    id_alu_src    = 1'($urandom_range(0, 1));
    id_rs         = RW'($urandom_range(0, 7));
    id_rt         = RW'($urandom_range(0, 7));
    id_rd         = RW'($urandom_range(0, 7));
    id_reg_write  = 1'($urandom_range(0, 1));
    id_mem_read   = ($urandom_range(0, 2) == 0);
    id_mem_write  = 1'($urandom_range(0, 1));
    id_mem_to_reg = 1'($urandom_range(0, 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    m = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("reset_valid", 64'(ex_valid), 64'd0);
    @(negedge clk);
    rst_n = 1;

    // Basic capture, then asynchronous reset in the middle of a cycle.
    drive_instr(2'd0, 32'd5, 32'd7, 32'd0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    tick();
    check("cap_a", 64'(ex_a), 64'd5);
    check("cap_b", 64'(ex_b), 64'd7);
    check("cap_rd", 64'(ex_rd), 64'd3);
    check("cap_valid", 64'(ex_valid), 64'd1);
    #2;
    rst_n = 0;
    #1;
    m = '0;
    check_all();
    check("midreset_reg_write", 64'(ex_reg_write), 64'd0);
    #1;
    rst_n = 1;

    // EX/MEM over MEM/WB forwarding on rs.
    drive_instr(2'd1, 32'h11, 32'h22, 32'd0, 1'b0, 5'd4, 5'd6, 5'd9, 1'b1, 1'b0);
    tick();
    exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'h100;
    settle();
    check("fwd_exmem", 64'(ex_a), 64'h100);
    memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'h200;
    settle();
    check("fwd_exmem_wins", 64'(ex_a), 64'h100);
    exmem_reg_write = 0;
    settle();
    check("fwd_memwb", 64'(ex_a), 64'h200);
    memwb_reg_write = 0;

    // Register 0 is never forwarded.
    drive_instr(2'd0, 32'd0, 32'd3, 32'd0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
    tick();
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFFFF;
    settle();
    check("fwd_r0", 64'(ex_a), 64'd0);
    exmem_reg_write = 0;

    // Load-use: lw r8 in EX, dependent instruction in ID.
    drive_instr(2'd0, 32'h40, 32'd0, 32'd4, 1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1);
    tick();
    drive_instr(2'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd8, 5'd3, 5'd10, 1'b1, 1'b0);
    settle();
    check("lu_flag", 64'(load_use), 64'd1);
    tick();
    check("lu_bubble_valid", 64'(ex_valid), 64'd0);
    check("lu_bubble_rw", 64'(ex_reg_write), 64'd0);
    drive_instr(2'd0, 32'h40, 32'd0, 32'd4, 1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1);
    tick();
    drive_instr(2'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd9, 5'd2, 5'd10, 1'b1, 1'b0);
    settle();
    check("lu_independent", 64'(load_use), 64'd0);

    // Immediate operand for an arithmetic shift right.
    drive_instr(2'd3, 32'h8000_0000, 32'd1, 32'hFFFF_FFFC, 1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
    tick();
    check("imm_b", 64'(ex_b), 64'hFFFF_FFFC);
    check("imm_a", 64'(ex_a), 64'h8000_0000);
    check("imm_ctl", 64'(ex_alu_ctl), 64'd3);
    check("imm_shamt", 64'(ex_b[5:0]), 64'd60);

    // Hold freezes, hold+flush gives a bubble, release captures.
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      randomize_id();
      tick();
      check("hold_a", 64'(ex_a), 64'h8000_0000);
      check("hold_b", 64'(ex_b), 64'hFFFF_FFFC);
    end
    flush = 1;
    tick();
    check("flush_valid", 64'(ex_valid), 64'd0);
    hold = 0; flush = 0;
    drive_instr(2'd2, 32'h1234, 32'h3, 32'd0, 1'b0, 5'd11, 5'd12, 5'd13, 1'b1, 1'b0);
    tick();
    check("release_a", 64'(ex_a), 64'h1234);
    check("release_rd", 64'(ex_rd), 64'd13);

    // Randomized traffic with small index space to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      randomize_id();
      hold            = ($urandom_range(0, 7) == 0);
      flush           = ($urandom_range(0, 9) == 0);
      exmem_reg_write = 1'($urandom_range(0, 1));
      exmem_rd        = RW'($urandom_range(0, 7));
      exmem_result    = $urandom;
      memwb_reg_write = 1'($urandom_range(0, 1));
      memwb_rd        = RW'($urandom_range(0, 7));
      memwb_result    = $urandom;
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
